// File: rtl/logo_reader.sv
// Logo reader: emits one control packet carrying the logo dimensions, then streams the
// logo pixels from memory in raster order; re-arms on each end-of-frame from the main stream.
module logo_reader #(
    parameter int LOGO_W    = 64,
    parameter int LOGO_H    = 32,
    parameter int AW        = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_eop,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [23:0]   mem_rddata,
    output logic [35:0]   control_logo_data,
    output logic          control_logo_valid,
    output logic [23:0]   logo_data,
    output logic          logo_valid,
    output logic          logo_sop,
    output logic          logo_eop,
    input  logic          logo_ready,
    output logic          busy
);
    localparam int            IW        = AW + 1;
    localparam logic [IW-1:0] NPIX      = IW'(LOGO_W * LOGO_H);
    localparam logic [IW-1:0] LAST      = IW'(LOGO_W * LOGO_H - 1);
    localparam logic [35:0]   CTRL_WORD = {16'(LOGO_W), 16'(LOGO_H), 4'h0};

    typedef enum logic [1:0] {
        S_CTRL   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    count_q, count_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [23:0]   fifo_mem [2];

    logic          rd_en;
    logic          ctrl_en;
    logic          flush;
    logic          push;
    logic          head_valid;
    logic          xfer;
    logic [23:0]   head_data;

    // The word returning from memory is visible at the head while the FIFO is empty,
    // so a pixel appears the cycle its data arrives and a full-rate stream needs no bubble.
    assign push       = inflight_q;
    assign head_valid = (state_q == S_STREAM) && ((count_q != 2'd0) || inflight_q);
    assign xfer       = head_valid && logo_ready;
    assign head_data  = (count_q == 2'd0) ? mem_rddata : fifo_mem[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        out_idx_d  = out_idx_q;
        inflight_d = 1'b0;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_en      = 1'b0;
        ctrl_en    = 1'b0;
        flush      = 1'b0;
        case (state_q)
            S_CTRL: begin
                ctrl_en = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                rd_en      = (rd_idx_q < NPIX) && ((count_q + 2'(inflight_q)) < 2'd2);
                inflight_d = rd_en;
                if (rd_en) rd_idx_d = rd_idx_q + IW'(1);
                if (push) wr_ptr_d = !wr_ptr_q;
                if (xfer) begin
                    rd_ptr_d  = !rd_ptr_q;
                    out_idx_d = out_idx_q + IW'(1);
                end
                count_d = count_q + 2'(push) - 2'(xfer);
                if (frame_eop) begin
                    state_d = S_CTRL;
                    flush   = 1'b1;
                end else if (xfer && (out_idx_q == LAST)) begin
                    state_d = S_WAIT;
                    flush   = 1'b1;
                end
            end
            S_WAIT: begin
                if (frame_eop) state_d = S_CTRL;
            end
            default: state_d = S_CTRL;
        endcase
        // Dropping the in-flight flag discards any read still returning from memory.
        if (flush) begin
            rd_idx_d   = '0;
            out_idx_d  = '0;
            inflight_d = 1'b0;
            count_d    = '0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_CTRL;
            rd_idx_q   <= '0;
            out_idx_q  <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            out_idx_q  <= out_idx_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_rddata;
    end

    // Reset holds the state in CTRL; outputs are masked so nothing is emitted until release.
    assign mem_rd             = !rst && rd_en;
    assign mem_addr           = rst ? '0 : AW'(BASE_ADDR) + rd_idx_q[AW-1:0];
    assign control_logo_valid = !rst && ctrl_en;
    assign control_logo_data  = rst ? '0 : CTRL_WORD;
    assign logo_valid         = !rst && head_valid;
    assign logo_data          = rst ? '0 : head_data;
    assign logo_sop           = !rst && head_valid && (out_idx_q == '0);
    assign logo_eop           = !rst && head_valid && (out_idx_q == LAST);
    assign busy               = !rst && (state_q != S_WAIT);

endmodule

// File: tb/tb_logo_reader.sv
// Bench for logo_reader: 4x2 logo over a registered memory with mem[i]=i; directed scenarios
// followed by randomized ready/frame_eop traffic checked against a transaction-level model.
`timescale 1ns/1ps
module tb_logo_reader;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int NP = W * H;
    localparam int AW = 5;
    localparam logic [35:0] CTRL_EXP = 36'h000400020;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_eop = 1'b0;
    logic          logo_ready = 1'b0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_rddata;
    logic [35:0]   control_logo_data;
    logic          control_logo_valid;
    logic [23:0]   logo_data;
    logic          logo_valid, logo_sop, logo_eop, busy;

    int n_chk  = 0;
    int n_fail = 0;

    logo_reader #(.LOGO_W(W), .LOGO_H(H), .AW(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .frame_eop(frame_eop),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rddata(mem_rddata),
        .control_logo_data(control_logo_data), .control_logo_valid(control_logo_valid),
        .logo_data(logo_data), .logo_valid(logo_valid), .logo_sop(logo_sop),
        .logo_eop(logo_eop), .logo_ready(logo_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Registered memory, mem[i] = i; junk on idle cycles exposes use of stale read data.
    always @(posedge clk) mem_rddata <= mem_rd ? 24'(mem_addr) : 24'($urandom);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [70:0] outs;
        rst = 1'b1;
        logo_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            frame_eop = 1'($urandom);
            @(negedge clk);
            outs = {mem_rd, mem_addr, control_logo_data, control_logo_valid, logo_data,
                    logo_valid, logo_sop, logo_eop, busy};
            n_chk++;
            if (outs !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d got %h want 0", c, outs);
            end
            step();
        end
        frame_eop = 1'b0;
    endtask

    task automatic test_basic();
        rst = 1'b0;
        logo_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            n_chk++;
            if (control_logo_valid !== (c == 1) || (c == 1 && control_logo_data !== CTRL_EXP)) begin
                n_fail++;
                $display("FAIL basic_ctrl cyc%0d got v=%b d=%h want v=%b d=%h",
                         c, control_logo_valid, control_logo_data, c == 1, CTRL_EXP);
            end
            n_chk++;
            if (mem_rd !== (c >= 2 && c <= 9) || (mem_rd === 1'b1 && mem_addr !== AW'(c - 2))) begin
                n_fail++;
                $display("FAIL basic_rd cyc%0d got rd=%b addr=%0d want rd=%b addr=%0d",
                         c, mem_rd, mem_addr, c >= 2 && c <= 9, c - 2);
            end
            n_chk++;
            if (logo_valid !== (c >= 3 && c <= 10) ||
                (logo_valid === 1'b1 && (logo_data !== 24'(c - 3) || logo_sop !== (c == 3) ||
                                         logo_eop !== (c == 10)))) begin
                n_fail++;
                $display("FAIL basic_pix cyc%0d got v=%b d=%0d sop=%b eop=%b want v=%b d=%0d",
                         c, logo_valid, logo_data, logo_sop, logo_eop, c >= 3 && c <= 10, c - 3);
            end
            n_chk++;
            if (busy !== (c <= 10)) begin
                n_fail++;
                $display("FAIL basic_busy cyc%0d got %b want %b", c, busy, c <= 10);
            end
            $display("basic cyc=%0d rd=%b addr=%0d valid=%b data=%0d", c, mem_rd, mem_addr,
                     logo_valid, logo_data);
            step();
        end
    endtask

    task automatic test_wait_restart();
        logo_ready = 1'b1;
        frame_eop  = 1'b1;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || logo_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle got busy=%b valid=%b want 0/0", busy, logo_valid);
        end
        step();
        frame_eop = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_chk++;
                if (control_logo_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL restart_ctrl got %b want 1", control_logo_valid);
                end
            end
            if (c == 2) begin
                n_chk++;
                if (mem_rd !== 1'b1 || mem_addr !== '0) begin
                    n_fail++;
                    $display("FAIL restart_addr got rd=%b addr=%0d want 1/0", mem_rd, mem_addr);
                end
            end
            if (c == 3) begin
                n_chk++;
                if (logo_valid !== 1'b1 || logo_data !== 24'd0 || logo_sop !== 1'b1) begin
                    n_fail++;
                    $display("FAIL restart_sop got v=%b d=%0d sop=%b want 1/0/1",
                             logo_valid, logo_data, logo_sop);
                end
            end
            if (c == 11) begin
                n_chk++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL restart_done got busy=%b want 0", busy);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int          exp_px = 0;
        int          outst  = 0;
        bit          held   = 1'b0;
        bit          done   = 1'b0;
        logic [23:0] prev   = '0;
        frame_eop = 1'b1;
        step();
        frame_eop = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            logo_ready = 1'(c % 2);
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                n_chk++;
                if (outst >= 2) begin
                    n_fail++;
                    $display("FAIL bp_occupancy cyc%0d got outstanding=%0d before read want <2", c, outst);
                end
                outst++;
            end
            if (held) begin
                n_chk++;
                if (logo_valid !== 1'b1 || logo_data !== prev) begin
                    n_fail++;
                    $display("FAIL bp_stable cyc%0d got v=%b d=%0d want 1/%0d", c, logo_valid, logo_data, prev);
                end
            end
            if (logo_valid === 1'b1 && logo_ready) begin
                n_chk++;
                if (logo_data !== 24'(exp_px) || logo_sop !== (exp_px == 0) || logo_eop !== (exp_px == NP - 1)) begin
                    n_fail++;
                    $display("FAIL bp_pix got d=%0d sop=%b eop=%b want d=%0d", logo_data, logo_sop,
                             logo_eop, exp_px);
                end
                $display("bp xfer pix=%0d data=%0d sop=%b eop=%b", exp_px, logo_data, logo_sop, logo_eop);
                exp_px++;
                outst--;
                if (exp_px == NP) done = 1'b1;
            end
            held = (logo_valid === 1'b1) && !logo_ready;
            prev = logo_data;
            step();
        end
        @(negedge clk);
        n_chk++;
        if (exp_px != NP || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_count got pixels=%0d busy=%b want %0d/0", exp_px, busy, NP);
        end
        step();
    endtask

    task automatic test_abort();
        frame_eop  = 1'b1;
        logo_ready = 1'b1;
        step();
        for (int c = 1; c <= 18; c++) begin
            logo_ready = (c != 7);
            frame_eop  = (c == 7);
            @(negedge clk);
            if (c == 6 || c == 7) begin
                n_chk++;
                if (logo_valid !== 1'b1 || logo_data !== 24'(c - 3) || logo_eop !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_pix cyc%0d got v=%b d=%0d eop=%b want 1/%0d/0",
                             c, logo_valid, logo_data, logo_eop, c - 3);
                end
            end
            if (c == 8) begin
                n_chk++;
                if (control_logo_valid !== 1'b1 || logo_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_ctrl got ctrl=%b valid=%b want 1/0", control_logo_valid, logo_valid);
                end
            end
            if (c == 9) begin
                n_chk++;
                if (mem_rd !== 1'b1 || mem_addr !== '0 || logo_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_addr got rd=%b addr=%0d valid=%b want 1/0/0", mem_rd, mem_addr, logo_valid);
                end
            end
            if (c == 10) begin
                n_chk++;
                if (logo_valid !== 1'b1 || logo_data !== 24'd0 || logo_sop !== 1'b1) begin
                    n_fail++;
                    $display("FAIL abort_sop got v=%b d=%0d sop=%b want 1/0/1", logo_valid, logo_data, logo_sop);
                end
            end
            if (c == 18) begin
                n_chk++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_done got busy=%b want 0", busy);
                end
            end
            step();
        end
        frame_eop = 1'b0;
    endtask

    task automatic test_eop_abort();
        frame_eop  = 1'b1;
        logo_ready = 1'b1;
        step();
        for (int c = 1; c <= 21; c++) begin
            frame_eop = (c == 10);
            @(negedge clk);
            if (c == 10) begin
                n_chk++;
                if (logo_eop !== 1'b1 || logo_data !== 24'd7) begin
                    n_fail++;
                    $display("FAIL eopabort_eop got eop=%b d=%0d want 1/7", logo_eop, logo_data);
                end
            end
            if (c == 11) begin
                n_chk++;
                if (control_logo_valid !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL eopabort_ctrl got ctrl=%b busy=%b want 1/1", control_logo_valid, busy);
                end
            end
            if (c == 12) begin
                n_chk++;
                if (mem_rd !== 1'b1 || mem_addr !== '0) begin
                    n_fail++;
                    $display("FAIL eopabort_addr got rd=%b addr=%0d want 1/0", mem_rd, mem_addr);
                end
            end
            if (c == 21) begin
                n_chk++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL eopabort_done got busy=%b want 0", busy);
                end
            end
            step();
        end
        frame_eop = 1'b0;
    endtask

    task automatic test_rst_mid();
        logic [70:0] outs;
        frame_eop  = 1'b1;
        logo_ready = 1'b1;
        step();
        frame_eop = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            logo_ready = (c != 8);
            @(negedge clk);
            if (c == 8) begin
                n_chk++;
                if (logo_valid !== 1'b1 || logo_data !== 24'd5) begin
                    n_fail++;
                    $display("FAIL rstmid_pending got v=%b d=%0d want 1/5", logo_valid, logo_data);
                end
            end
            step();
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            outs = {mem_rd, mem_addr, control_logo_data, control_logo_valid, logo_data,
                    logo_valid, logo_sop, logo_eop, busy};
            n_chk++;
            if (outs !== '0) begin
                n_fail++;
                $display("FAIL rstmid_outputs cyc%0d got %h want 0", c, outs);
            end
            step();
        end
        rst = 1'b0;
        logo_ready = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_chk++;
                if (control_logo_valid !== 1'b1 || control_logo_data !== CTRL_EXP) begin
                    n_fail++;
                    $display("FAIL rstmid_ctrl got v=%b d=%h want 1/%h", control_logo_valid, control_logo_data, CTRL_EXP);
                end
            end
            if (c == 3) begin
                n_chk++;
                if (logo_valid !== 1'b1 || logo_data !== 24'd0 || logo_sop !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rstmid_sop got v=%b d=%0d sop=%b want 1/0/1", logo_valid, logo_data, logo_sop);
                end
            end
            if (c == 11) begin
                n_chk++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstmid_done got busy=%b want 0", busy);
                end
            end
            step();
        end
    endtask

    // Transaction-level model: 0 = control packet due, 1 = streaming, 2 = idle.
    task automatic test_random();
        int phase  = 2;
        int rd_nxt = 0;
        int exp_px = 0;
        int outst  = 0;
        bit exp_rd, exp_v;
        for (int cyc = 0; cyc < 800; cyc++) begin
            logo_ready = ($urandom_range(0, 99) < 70);
            frame_eop  = ($urandom_range(0, 99) < ((phase == 2) ? 30 : 4));
            @(negedge clk);
            case (phase)
                0: begin
                    n_chk++;
                    if ({control_logo_valid, mem_rd, logo_valid, busy} !== 4'b1001 ||
                        control_logo_data !== CTRL_EXP) begin
                        n_fail++;
                        $display("FAIL rand_ctrl cyc%0d got ctrl/rd/v/busy=%b%b%b%b want 1001",
                                 cyc, control_logo_valid, mem_rd, logo_valid, busy);
                    end
                    $display("rand ctrl packet data=%h", control_logo_data);
                    phase = 1; rd_nxt = 0; exp_px = 0; outst = 0;
                end
                1: begin
                    exp_rd = (rd_nxt < NP) && (outst < 2);
                    exp_v  = (outst > 0);
                    n_chk++;
                    if (mem_rd !== exp_rd || (exp_rd && mem_addr !== AW'(rd_nxt)) ||
                        control_logo_valid !== 1'b0 || busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL rand_rd cyc%0d got rd=%b addr=%0d busy=%b want rd=%b addr=%0d busy=1",
                                 cyc, mem_rd, mem_addr, busy, exp_rd, rd_nxt);
                    end
                    n_chk++;
                    if (logo_valid !== exp_v || (exp_v && (logo_data !== 24'(exp_px) ||
                        logo_sop !== (exp_px == 0) || logo_eop !== (exp_px == NP - 1)))) begin
                        n_fail++;
                        $display("FAIL rand_pix cyc%0d got v=%b d=%0d sop=%b eop=%b want v=%b d=%0d",
                                 cyc, logo_valid, logo_data, logo_sop, logo_eop, exp_v, exp_px);
                    end
                    if (exp_rd) begin rd_nxt++; outst++; end
                    if (exp_v && logo_ready) begin
                        $display("rand xfer pix=%0d data=%0d sop=%b eop=%b", exp_px, logo_data, logo_sop, logo_eop);
                        outst--;
                        exp_px++;
                    end
                    if (frame_eop) phase = 0;
                    else if (exp_v && logo_ready && exp_px == NP) phase = 2;
                end
                default: begin
                    n_chk++;
                    if ({busy, logo_valid, mem_rd, control_logo_valid} !== 4'b0000) begin
                        n_fail++;
                        $display("FAIL rand_idle cyc%0d got busy/v/rd/ctrl=%b%b%b%b want 0000",
                                 cyc, busy, logo_valid, mem_rd, control_logo_valid);
                    end
                    if (frame_eop) phase = 0;
                end
            endcase
            step();
        end
        frame_eop = 1'b0;
    endtask

    initial begin
        #2;
        rst = 1'b1;
        step();
        test_reset();
        test_basic();
        test_wait_restart();
        test_backpressure();
        test_abort();
        test_eop_abort();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
